uart_tx_fifo: RTL and testbench

- Transmit-side serial stage of the Enigma UART path: buffers bytes produced by the cipher FSM (banner text, ciphertext letters) and serializes them onto the UART TX pin as 8N1 frames.
- Sits between the FSM/forward-path output and the `uart_tx` top-level pin.
- Decouples FSM byte bursts (e.g. the 16-character banner) from line rate: 12 MHz clock, 104 clocks per bit.

---
 rtl/uart_tx_fifo.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Summary  : Byte FIFO feeding an 8N1 UART transmitter (LSB first, tx idles
//            high). Defining UART_TX_PARITY_EN adds an even-parity bit
//            between the data bits and the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              tx,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_CNT_W  = ADDR_W + 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_wr_ready;
    logic                r_overflow;

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic [c_BAUD_W-1:0] r_baud;
    logic [c_BAUD_W-1:0] w_baud_next;
    logic [2:0]          r_bit_idx;
    logic [2:0]          w_bit_next;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_next;
    logic                r_tx;
    logic                w_tx_next;

    logic                w_push;
    logic                w_pop;
    logic                w_baud_done;
    logic                w_fifo_nonempty;
    logic [7:0]          w_head;
    logic [ADDR_W:0]     w_count_next;

    assign w_push          = wr_valid && r_wr_ready;
    assign w_baud_done     = (r_baud == c_BAUD_LAST);
    assign w_fifo_nonempty = (r_count != '0);
    assign w_head          = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------
    // FIFO storage and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count    <= w_count_next;
            r_wr_ready <= (w_count_next != c_FULL);
            // A write against a full FIFO is lost even if a pop frees a slot.
            if (wr_valid && !r_wr_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_baud    <= w_baud_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + c_BAUD_W'(1);
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (w_fifo_nonempty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) begin
                    w_baud_next  = '0;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_done) begin
                    w_baud_next = '0;
                    // Back-to-back frames: next start bit follows the stop bit directly.
                    if (w_fifo_nonempty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The line level is registered from the next state so tx never glitches.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[w_bit_next];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = ^w_shift_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    assign tx         = r_tx;
    assign wr_ready   = r_wr_ready;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign busy       = (r_state != S_IDLE) || w_fifo_nonempty;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Summary  : Directed bench for uart_tx_fifo with a queue-based frame model
//            and a mid-bit sampling receiver (honours UART_TX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int CLKS  = 104;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] A_RAW = 11'h482;
`else
    localparam int NB = 10;
    localparam logic [10:0] A_RAW = 11'h282;
`endif
    localparam int FRAME   = NB * CLKS;
    localparam int MAX_ERR = 40;

    logic          clk;
    logic          rst;
    logic [7:0]    wr_data;
    logic          wr_valid;
    logic          wr_ready;
    logic          tx;
    logic          busy;
    logic [AW:0]   fifo_count;
    logic          overflow;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CLKS),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_W       (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   chk_en = 1'b0;

    // Reference model: byte queue plus position inside the current frame.
    logic [7:0] mq[$];
    int         m_t     = -1;
    logic [7:0] m_cur   = 8'h00;
    logic       m_ready = 1'b1;
    logic       m_ovf   = 1'b0;

    // Line receiver results.
    logic [7:0]  rx_data[$];
    logic [10:0] rx_raw[$];
    int          rx_starts[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic finish_run;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
            if (errors >= MAX_ERR) finish_run();
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[3'(pos - 1)];
`ifdef UART_TX_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Per-cycle compare, receiver, then model step for the coming edge.
    initial begin : p_mon
        logic       acc;
        logic       e_tx;
        logic       e_busy;
        logic       rx_on;
        int         rx_cnt;
        int         pos;
        logic [10:0] rx_cur;
        rx_on  = 1'b0;
        rx_cnt = 0;
        rx_cur = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (chk_en) begin
                e_tx   = (m_t < 0) ? 1'b1 : frame_bit(m_cur, m_t / CLKS);
                e_busy = (m_t >= 0) || (mq.size() != 0);
                check($sformatf("cycle%0d {tx,busy,wr_ready,overflow,fifo_count}", cyc),
                      {tx, busy, wr_ready, overflow, fifo_count},
                      {e_tx, e_busy, m_ready, m_ovf, 5'(mq.size())});
            end

            if (rst !== 1'b0) begin
                rx_on = 1'b0;
            end else if (!rx_on) begin
                if (chk_en && tx === 1'b0) begin
                    rx_on  = 1'b1;
                    rx_cnt = 0;
                    rx_cur = '0;
                    rx_starts.push_back(cyc);
                end
            end else begin
                rx_cnt++;
            end
            if (rx_on && (rx_cnt % CLKS) == CLKS / 2) begin
                pos = rx_cnt / CLKS;
                rx_cur[4'(pos)] = tx;
                if (pos == NB - 1) begin
                    rx_on = 1'b0;
                    check("rx_framing {start,stop}", {rx_cur[0], rx_cur[NB-1]}, 2'b01);
                    rx_data.push_back(rx_cur[8:1]);
                    rx_raw.push_back(rx_cur);
                end
            end

            if (rst !== 1'b0) begin
                mq.delete();
                m_t     = -1;
                m_ready = 1'b1;
                m_ovf   = 1'b0;
            end else begin
                acc = (wr_valid === 1'b1) && m_ready;
                if (wr_valid === 1'b1 && !m_ready) m_ovf = 1'b1;
                if (m_t < 0 || m_t == FRAME - 1) begin
                    if (mq.size() != 0) begin
                        m_cur = mq.pop_front();
                        m_t   = 0;
                    end else begin
                        m_t = -1;
                    end
                end else begin
                    m_t++;
                end
                if (acc) mq.push_back(wr_data);
                m_ready = (mq.size() != DEPTH);
            end
        end
    end

    initial begin : p_watchdog
        repeat (95000) @(posedge clk);
        errors++;
        $display("FAIL watchdog: got cycle limit reached, expected completion");
        finish_run();
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        check("drain_timeout busy", busy, 1'b0);
    endtask

    task automatic clear_rx;
        rx_data.delete();
        rx_raw.delete();
        rx_starts.delete();
    endtask

    initial begin : p_stim
        int    n;
        int    peak;
        string banner;
        banner   = "ENIGMA M3 READY\n";
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        tick();
        tick();
        chk_en = 1'b1;
        check("reset tx", tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset wr_ready", wr_ready, 1'b1);
        check("reset fifo_count", fifo_count, 0);
        check("reset overflow", overflow, 1'b0);
        rst = 1'b0;
        tick();

        // Single byte 'A'
        wr_data = 8'h41; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
        check("t1 count after accept", fifo_count, 1);
        check("t1 tx before pop", tx, 1'b1);
        tick();
        check("t1 tx falls", tx, 1'b0);
        check("t1 count after pop", fifo_count, 0);
        check("t1 busy", busy, 1'b1);
        wait_idle(2 * FRAME, n);
        check("t1 busy length", n, FRAME);
        check("t1 rx count", rx_data.size(), 1);
        if (rx_data.size() >= 1) begin
            check("t1 rx byte", rx_data[0], 8'h41);
            check("t1 line bits", rx_raw[0], A_RAW);
        end
        clear_rx();
        repeat (5) tick();

        // Write during transmission: 0x43 while 0x41 is in its data bits
        wr_data = 8'h41; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
        repeat (300) tick();
        wr_data = 8'h43; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
        check("t6 count", fifo_count, 1);
        wait_idle(3 * FRAME, n);
        check("t6 rx count", rx_data.size(), 2);
        check("t6 start count", rx_starts.size(), 2);
        if (rx_data.size() == 2 && rx_starts.size() == 2) begin
            check("t6 rx byte0", rx_data[0], 8'h41);
            check("t6 rx byte1", rx_data[1], 8'h43);
            check("t6 start spacing", rx_starts[1] - rx_starts[0], FRAME);
`ifdef UART_TX_PARITY_EN
            check("t6 parity 0x41", rx_raw[0][9], 1'b0);
            check("t6 parity 0x43", rx_raw[1][9], 1'b1);
            check("t6 stop after parity", rx_raw[1][10], 1'b1);
`endif
        end
        clear_rx();
        repeat (5) tick();

        // Banner burst
        peak = 0;
        for (int i = 0; i < 16; i++) begin
            wr_data  = banner[i];
            wr_valid = 1'b1;
            tick();
            check($sformatf("t2 wr_ready %0d", i), wr_ready, 1'b1);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        wr_valid = 1'b0;
        check("t2 peak 15 or 16", (peak == 15 || peak == 16), 1'b1);
        check("t2 overflow", overflow, 1'b0);
        wait_idle(17 * FRAME, n);
        check("t2 rx count", rx_data.size(), 16);
        if (rx_data.size() == 16 && rx_starts.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("t2 rx byte %0d", i), rx_data[i], banner[i]);
            end
            check("t2 contiguous span", rx_starts[15] - rx_starts[0], 15 * FRAME);
        end
        clear_rx();
        repeat (5) tick();

        // Overflow: 18 back-to-back writes, first goes straight on the line
        for (int i = 0; i < 18; i++) begin
            wr_data  = 8'(8'h60 + i);
            wr_valid = 1'b1;
            tick();
            if (i == 16) begin
                check("t3 count full", fifo_count, DEPTH);
                check("t3 wr_ready low", wr_ready, 1'b0);
            end
        end
        wr_valid = 1'b0;
        check("t3 overflow", overflow, 1'b1);
        check("t3 count after drop", fifo_count, DEPTH);
        wait_idle(18 * FRAME, n);
        check("t3 rx count", rx_data.size(), 17);
        if (rx_data.size() == 17) begin
            for (int i = 0; i < 17; i++) begin
                check($sformatf("t3 rx byte %0d", i), rx_data[i], 8'(8'h60 + i));
            end
        end
        clear_rx();
        repeat (5) tick();

        // Reset in bit 3 of 0x5A with three bytes queued
        wr_valid = 1'b1;
        wr_data = 8'h5A; tick();
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_valid = 1'b0;
        check("t4 queued", fifo_count, 3);
        repeat (4 * CLKS + 50 - 2) tick();
        check("t4 mid bit3 of 0x5A", tx, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("t4 tx after rst", tx, 1'b1);
        check("t4 count after rst", fifo_count, 0);
        check("t4 busy after rst", busy, 1'b0);
        check("t4 overflow after rst", overflow, 1'b0);
        clear_rx();
        repeat (3 * FRAME) tick();
        check("t4 no further frames", rx_starts.size(), 0);
        wr_data = 8'h42; wr_valid = 1'b1; tick(); wr_valid = 1'b0;
        tick();
        wait_idle(2 * FRAME, n);
        check("t4 rx count", rx_data.size(), 1);
        if (rx_data.size() == 1) begin
            check("t4 rx byte", rx_data[0], 8'h42);
        end
        repeat (5) tick();
        finish_run();
    end

endmodule

`default_nettype wire
